// File: rtl/local_net_iface.sv
`default_nettype none
// ============================================================================
//  Module      : local_net_iface
//  Description : Network interface between a processing element and the
//                LOCAL port of a mesh router. It has a TX FIFO that injects
//                flits under the router's full flag, and an RX FIFO
//                (first-word fall-through) that feeds the PE. It also keeps
//                traffic counters and sticky error flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module local_net_iface #(
    parameter logic [2:0] ROUTER_ADDRESS = 3'b000,
    parameter int         TX_DEPTH       = 4,
    parameter int         RX_DEPTH       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [25:0] pe_tx_payload,
    input  logic [2:0]  pe_tx_dst,
    input  logic        pe_tx_valid,
    output logic        pe_tx_ready,
    output logic [31:0] noc_tx_data,
    output logic        noc_tx_valid,
    input  logic        noc_tx_full,
    input  logic [31:0] noc_rx_data,
    input  logic        noc_rx_valid,
    output logic [25:0] pe_rx_payload,
    output logic [2:0]  pe_rx_src,
    output logic        pe_rx_valid,
    input  logic        pe_rx_ready,
    input  logic        stat_clr,
    output logic [15:0] tx_cnt,
    output logic [15:0] rx_cnt,
    output logic [7:0]  drop_cnt,
    output logic        rx_overflow,
    output logic        misroute
);

    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);

    logic [31:0]    r_tx_mem [TX_DEPTH];
    logic [TX_AW:0] r_tx_wr_ptr, r_tx_rd_ptr;
    logic [31:0]    r_rx_mem [RX_DEPTH];
    logic [RX_AW:0] r_rx_wr_ptr, r_rx_rd_ptr;
    logic [31:0]    r_tx_data;
    logic           r_tx_valid;
    logic [15:0]    r_tx_cnt, r_rx_cnt;
    logic [7:0]     r_drop_cnt;
    logic           r_rx_overflow, r_misroute;

    logic        w_tx_empty, w_tx_full, w_tx_push, w_tx_pop;
    logic        w_rx_empty, w_rx_full, w_rx_pop, w_rx_wr, w_rx_drop, w_misroute;
    logic [31:0] w_tx_flit, w_rx_head;

    // When the pointers differ only in their wrap bit, the FIFO is full.
    assign w_tx_empty = (r_tx_wr_ptr == r_tx_rd_ptr);
    assign w_tx_full  = (r_tx_wr_ptr[TX_AW] != r_tx_rd_ptr[TX_AW]) &&
                        (r_tx_wr_ptr[TX_AW-1:0] == r_tx_rd_ptr[TX_AW-1:0]);
    assign w_rx_empty = (r_rx_wr_ptr == r_rx_rd_ptr);
    assign w_rx_full  = (r_rx_wr_ptr[RX_AW] != r_rx_rd_ptr[RX_AW]) &&
                        (r_rx_wr_ptr[RX_AW-1:0] == r_rx_rd_ptr[RX_AW-1:0]);

    assign pe_tx_ready = !w_tx_full;
    assign w_tx_push   = pe_tx_valid && !w_tx_full;
    assign w_tx_pop    = !w_tx_empty && !noc_tx_full;
    assign w_tx_flit   = {pe_tx_payload, ROUTER_ADDRESS, pe_tx_dst};

    // A full RX FIFO still accepts a flit when the PE frees the head on the same edge.
    assign w_rx_pop    = !w_rx_empty && pe_rx_ready;
    assign w_rx_wr     = noc_rx_valid && (!w_rx_full || w_rx_pop);
    assign w_rx_drop   = noc_rx_valid && !w_rx_wr;
    assign w_misroute  = noc_rx_valid && (noc_rx_data[2:0] != ROUTER_ADDRESS);

    assign w_rx_head     = r_rx_mem[r_rx_rd_ptr[RX_AW-1:0]];
    assign pe_rx_valid   = !w_rx_empty;
    assign pe_rx_payload = w_rx_head[31:6];
    assign pe_rx_src     = w_rx_head[5:3];

    assign noc_tx_data  = r_tx_data;
    assign noc_tx_valid = r_tx_valid;
    assign tx_cnt       = r_tx_cnt;
    assign rx_cnt       = r_rx_cnt;
    assign drop_cnt     = r_drop_cnt;
    assign rx_overflow  = r_rx_overflow;
    assign misroute     = r_misroute;

    // Storage arrays: no reset is needed because the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wr_ptr[TX_AW-1:0]] <= w_tx_flit;
        if (w_rx_wr)   r_rx_mem[r_rx_wr_ptr[RX_AW-1:0]] <= noc_rx_data;
    end

    // FIFO pointers and the injection output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_wr_ptr <= '0;
            r_tx_rd_ptr <= '0;
            r_rx_wr_ptr <= '0;
            r_rx_rd_ptr <= '0;
            r_tx_data   <= '0;
            r_tx_valid  <= 1'b0;
        end else begin
            if (w_tx_push) r_tx_wr_ptr <= r_tx_wr_ptr + 1'b1;
            if (w_tx_pop)  r_tx_rd_ptr <= r_tx_rd_ptr + 1'b1;
            if (w_rx_wr)   r_rx_wr_ptr <= r_rx_wr_ptr + 1'b1;
            if (w_rx_pop)  r_rx_rd_ptr <= r_rx_rd_ptr + 1'b1;
            r_tx_valid <= w_tx_pop;
            r_tx_data  <= w_tx_pop ? r_tx_mem[r_tx_rd_ptr[TX_AW-1:0]] : 32'd0;
        end
    end

    // Statistics: if a clear and an event happen on the same edge, the clear wins.
    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            r_tx_cnt      <= '0;
            r_rx_cnt      <= '0;
            r_drop_cnt    <= '0;
            r_rx_overflow <= 1'b0;
            r_misroute    <= 1'b0;
        end else begin
            if (w_tx_pop) r_tx_cnt <= r_tx_cnt + 16'd1;
            if (w_rx_wr)  r_rx_cnt <= r_rx_cnt + 16'd1;
            if (w_rx_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
            if (w_rx_drop)  r_rx_overflow <= 1'b1;
            if (w_misroute) r_misroute    <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_local_net_iface.sv
`default_nettype none
// ============================================================================
//  Module      : tb_local_net_iface
//  Description : Self-checking bench for local_net_iface. A queue-based
//                transaction model steps in lockstep with the DUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_local_net_iface;

    localparam logic [2:0] RA       = 3'b110;
    localparam int         TX_DEPTH = 4;
    localparam int         RX_DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [25:0] pe_tx_payload = '0;
    logic [2:0]  pe_tx_dst = '0;
    logic        pe_tx_valid = 1'b0;
    logic        pe_tx_ready;
    logic [31:0] noc_tx_data;
    logic        noc_tx_valid;
    logic        noc_tx_full = 1'b0;
    logic [31:0] noc_rx_data = '0;
    logic        noc_rx_valid = 1'b0;
    logic [25:0] pe_rx_payload;
    logic [2:0]  pe_rx_src;
    logic        pe_rx_valid;
    logic        pe_rx_ready = 1'b0;
    logic        stat_clr = 1'b0;
    logic [15:0] tx_cnt, rx_cnt;
    logic [7:0]  drop_cnt;
    logic        rx_overflow, misroute;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    logic [31:0] m_txq[$];
    logic [31:0] m_rxq[$];
    logic        m_tx_valid;
    logic [31:0] m_tx_data;
    logic [15:0] m_tx_cnt, m_rx_cnt;
    logic [7:0]  m_drop;
    logic        m_ovf, m_mis;

    local_net_iface #(.ROUTER_ADDRESS(RA), .TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .pe_tx_payload(pe_tx_payload), .pe_tx_dst(pe_tx_dst),
        .pe_tx_valid(pe_tx_valid), .pe_tx_ready(pe_tx_ready),
        .noc_tx_data(noc_tx_data), .noc_tx_valid(noc_tx_valid), .noc_tx_full(noc_tx_full),
        .noc_rx_data(noc_rx_data), .noc_rx_valid(noc_rx_valid),
        .pe_rx_payload(pe_rx_payload), .pe_rx_src(pe_rx_src),
        .pe_rx_valid(pe_rx_valid), .pe_rx_ready(pe_rx_ready),
        .stat_clr(stat_clr), .tx_cnt(tx_cnt), .rx_cnt(rx_cnt), .drop_cnt(drop_cnt),
        .rx_overflow(rx_overflow), .misroute(misroute)
    );

    always #5 clk = ~clk;

    // One clock edge of the model, using the inputs currently applied.
    task automatic model_edge();
        bit tx_rdy, tx_pop, rx_pop, rx_wr, drop, mis;
        if (rst) begin
            m_txq.delete(); m_rxq.delete();
            m_tx_valid = 0; m_tx_data = 0;
            m_tx_cnt = 0; m_rx_cnt = 0; m_drop = 0; m_ovf = 0; m_mis = 0;
            return;
        end
        tx_rdy = m_txq.size() < TX_DEPTH;
        tx_pop = (m_txq.size() != 0) && !noc_tx_full;
        rx_pop = (m_rxq.size() != 0) && pe_rx_ready;
        rx_wr  = noc_rx_valid && ((m_rxq.size() < RX_DEPTH) || rx_pop);
        drop   = noc_rx_valid && !rx_wr;
        mis    = noc_rx_valid && (noc_rx_data[2:0] != RA);
        m_tx_valid = tx_pop;
        m_tx_data  = tx_pop ? m_txq[0] : 32'd0;
        if (tx_pop) void'(m_txq.pop_front());
        if (pe_tx_valid && tx_rdy) m_txq.push_back({pe_tx_payload, RA, pe_tx_dst});
        if (rx_pop) void'(m_rxq.pop_front());
        if (rx_wr) m_rxq.push_back(noc_rx_data);
        if (stat_clr) begin
            m_tx_cnt = 0; m_rx_cnt = 0; m_drop = 0; m_ovf = 0; m_mis = 0;
        end else begin
            if (tx_pop) m_tx_cnt = m_tx_cnt + 16'd1;
            if (rx_wr)  m_rx_cnt = m_rx_cnt + 16'd1;
            if (drop && m_drop != 8'hFF) m_drop = m_drop + 8'd1;
            if (drop) m_ovf = 1;
            if (mis)  m_mis = 1;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pe_tx_valid = 0; noc_rx_valid = 0; pe_rx_ready = 0;
        noc_tx_full = 0; stat_clr = 0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (noc_tx_valid !== 1'b0 || noc_tx_data !== 32'd0) begin errors++;
            $display("FAIL reset_tx_out: got valid=%b data=%h want 0/0", noc_tx_valid, noc_tx_data); end
        checks++; if (pe_rx_valid !== 1'b0 || pe_tx_ready !== 1'b1) begin errors++;
            $display("FAIL reset_fifo: got rx_valid=%b tx_ready=%b want 0/1", pe_rx_valid, pe_tx_ready); end
        checks++; if ({tx_cnt, rx_cnt, drop_cnt, rx_overflow, misroute} !== 42'd0) begin errors++;
            $display("FAIL reset_stats: got tx=%0d rx=%0d drop=%0d ovf=%b mis=%b want all 0",
                     tx_cnt, rx_cnt, drop_cnt, rx_overflow, misroute); end
    endtask

    task automatic test_tx_basic();
        apply_reset();
        pe_tx_valid = 1; pe_tx_payload = 26'h00000AB; pe_tx_dst = 3'b101;
        tick();
        pe_tx_valid = 0;
        checks++; if (noc_tx_valid !== 1'b0) begin errors++;
            $display("FAIL tx_basic_early: got valid=%b want 0", noc_tx_valid); end
        tick();
        checks++; if (noc_tx_valid !== 1'b1 || noc_tx_data !== {26'h00000AB, RA, 3'b101}) begin errors++;
            $display("FAIL tx_basic_flit: got valid=%b data=%h want 1/%h", noc_tx_valid, noc_tx_data,
                     {26'h00000AB, RA, 3'b101}); end
        checks++; if (tx_cnt !== 16'd1) begin errors++;
            $display("FAIL tx_basic_cnt: got %0d want 1", tx_cnt); end
        tick();
        checks++; if (noc_tx_valid !== 1'b0 || noc_tx_data !== 32'd0) begin errors++;
            $display("FAIL tx_basic_one_cycle: got valid=%b data=%h want 0/0", noc_tx_valid, noc_tx_data); end
    endtask

    task automatic test_tx_backpressure();
        apply_reset();
        noc_tx_full = 1;
        for (int i = 0; i < 6; i++) begin
            checks++; if (pe_tx_ready !== (i < TX_DEPTH)) begin errors++;
                $display("FAIL bp_ready[%0d]: got %b want %b", i, pe_tx_ready, (i < TX_DEPTH)); end
            pe_tx_valid = 1; pe_tx_payload = 26'(i + 16); pe_tx_dst = 3'(i);
            tick();
            checks++; if (noc_tx_valid !== 1'b0) begin errors++;
                $display("FAIL bp_no_inject[%0d]: got valid=%b want 0", i, noc_tx_valid); end
        end
        pe_tx_valid = 0; noc_tx_full = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (noc_tx_valid !== 1'b1 || noc_tx_data !== {26'(i + 16), RA, 3'(i)}) begin errors++;
                $display("FAIL bp_order[%0d]: got valid=%b data=%h want 1/%h", i, noc_tx_valid,
                         noc_tx_data, {26'(i + 16), RA, 3'(i)}); end
        end
        tick();
        checks++; if (noc_tx_valid !== 1'b0 || tx_cnt !== 16'd4) begin errors++;
            $display("FAIL bp_done: got valid=%b tx_cnt=%0d want 0/4", noc_tx_valid, tx_cnt); end
    endtask

    task automatic test_rx_overflow();
        logic [2:0] srcs [10];
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            srcs[i] = 3'($urandom_range(0, 7));
            noc_rx_valid = 1; noc_rx_data = {26'(i + 100), srcs[i], RA};
            tick();
        end
        noc_rx_valid = 0;
        checks++; if (rx_cnt !== 16'd8 || drop_cnt !== 8'd2 || rx_overflow !== 1'b1 || misroute !== 1'b0) begin errors++;
            $display("FAIL ovf_stats: got rx=%0d drop=%0d ovf=%b mis=%b want 8/2/1/0",
                     rx_cnt, drop_cnt, rx_overflow, misroute); end
        pe_rx_ready = 1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (pe_rx_valid !== 1'b1 || pe_rx_payload !== 26'(i + 100) || pe_rx_src !== srcs[i]) begin errors++;
                $display("FAIL ovf_pop[%0d]: got v=%b pl=%h src=%0d want 1/%h/%0d", i, pe_rx_valid,
                         pe_rx_payload, pe_rx_src, 26'(i + 100), srcs[i]); end
            tick();
        end
        pe_rx_ready = 0;
        checks++; if (pe_rx_valid !== 1'b0) begin errors++;
            $display("FAIL ovf_empty: got valid=%b want 0", pe_rx_valid); end
    endtask

    task automatic test_rx_full_pop();
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            noc_rx_valid = 1; noc_rx_data = {26'(i + 1), 3'd1, RA};
            tick();
        end
        noc_rx_data = {26'h3AB, 3'd2, RA}; pe_rx_ready = 1;
        tick();
        pe_rx_ready = 0;
        checks++; if (drop_cnt !== 8'd0 || rx_cnt !== 16'd9 || pe_rx_payload !== 26'd2) begin errors++;
            $display("FAIL full_pop: got drop=%0d rx=%0d head=%h want 0/9/2", drop_cnt, rx_cnt, pe_rx_payload); end
        noc_rx_data = {26'h3AC, 3'd2, RA};
        tick();
        noc_rx_valid = 0;
        checks++; if (drop_cnt !== 8'd1 || rx_cnt !== 16'd9) begin errors++;
            $display("FAIL full_pop_still_full: got drop=%0d rx=%0d want 1/9", drop_cnt, rx_cnt); end
    endtask

    task automatic test_misroute_clr();
        apply_reset();
        noc_rx_valid = 1; noc_rx_data = {26'h155, 3'd3, RA ^ 3'b010};
        tick();
        noc_rx_valid = 0;
        checks++; if (misroute !== 1'b1 || pe_rx_valid !== 1'b1 || pe_rx_payload !== 26'h155 || pe_rx_src !== 3'd3) begin errors++;
            $display("FAIL misroute: got mis=%b v=%b pl=%h src=%0d want 1/1/155/3", misroute,
                     pe_rx_valid, pe_rx_payload, pe_rx_src); end
        for (int i = 0; i < 7; i++) begin
            noc_rx_valid = 1; noc_rx_data = {26'(i), 3'd0, RA};
            tick();
        end
        noc_rx_data = {26'h7, 3'd0, RA ^ 3'b001}; stat_clr = 1;
        tick();
        noc_rx_valid = 0; stat_clr = 0;
        checks++; if ({tx_cnt, rx_cnt, drop_cnt, rx_overflow, misroute} !== 42'd0) begin errors++;
            $display("FAIL clr_wins: got tx=%0d rx=%0d drop=%0d ovf=%b mis=%b want all 0",
                     tx_cnt, rx_cnt, drop_cnt, rx_overflow, misroute); end
        checks++; if (pe_rx_valid !== 1'b1 || pe_rx_payload !== 26'h155) begin errors++;
            $display("FAIL clr_keeps_fifo: got v=%b pl=%h want 1/155", pe_rx_valid, pe_rx_payload); end
    endtask

    task automatic test_drop_saturate();
        apply_reset();
        noc_rx_valid = 1; noc_rx_data = {26'h1, 3'd0, RA};
        for (int i = 0; i < RX_DEPTH + 260; i++) tick();
        noc_rx_valid = 0;
        checks++; if (drop_cnt !== 8'hFF || rx_cnt !== 16'd8) begin errors++;
            $display("FAIL drop_saturate: got drop=%0d rx=%0d want 255/8", drop_cnt, rx_cnt); end
    endtask

    task automatic test_reset_midop();
        apply_reset();
        noc_tx_full = 1; pe_tx_valid = 1; noc_rx_valid = 1;
        for (int i = 0; i < 3; i++) begin
            pe_tx_payload = 26'(i); noc_rx_data = {26'(i), 3'd1, RA};
            tick();
        end
        pe_tx_valid = 0; noc_rx_valid = 0; noc_tx_full = 0;
        tick();
        rst = 1;
        tick();
        rst = 0;
        checks++; if (pe_rx_valid !== 1'b0 || noc_tx_valid !== 1'b0 || pe_tx_ready !== 1'b1) begin errors++;
            $display("FAIL midop_reset: got rx_v=%b tx_v=%b tx_rdy=%b want 0/0/1", pe_rx_valid, noc_tx_valid, pe_tx_ready); end
        checks++; if ({tx_cnt, rx_cnt, drop_cnt, rx_overflow, misroute} !== 42'd0) begin errors++;
            $display("FAIL midop_stats: got tx=%0d rx=%0d drop=%0d want 0", tx_cnt, rx_cnt, drop_cnt); end
        tick();
        checks++; if (noc_tx_valid !== 1'b0) begin errors++;
            $display("FAIL midop_tx_flushed: got valid=%b want 0", noc_tx_valid); end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 1500; c++) begin
            pe_tx_valid   = ($urandom_range(0, 99) < 60);
            pe_tx_payload = 26'($urandom());
            pe_tx_dst     = 3'($urandom());
            noc_tx_full   = ($urandom_range(0, 99) < 45);
            noc_rx_valid  = ($urandom_range(0, 99) < 55);
            noc_rx_data   = ($urandom_range(0, 9) == 0) ? $urandom() : {26'($urandom()), 3'($urandom()), RA};
            pe_rx_ready   = ($urandom_range(0, 99) < 45);
            stat_clr      = ($urandom_range(0, 59) == 0);
            rst           = ($urandom_range(0, 299) == 0);
            tick();
            checks++; if (noc_tx_valid !== m_tx_valid || noc_tx_data !== m_tx_data) begin errors++;
                $display("FAIL rand_tx[%0d]: got %b/%h want %b/%h", c, noc_tx_valid, noc_tx_data, m_tx_valid, m_tx_data); end
            checks++; if (pe_tx_ready !== (m_txq.size() < TX_DEPTH) || pe_rx_valid !== (m_rxq.size() != 0)) begin errors++;
                $display("FAIL rand_flags[%0d]: got rdy=%b rxv=%b want %b/%b", c, pe_tx_ready, pe_rx_valid,
                         (m_txq.size() < TX_DEPTH), (m_rxq.size() != 0)); end
            if (m_rxq.size() != 0) begin
                checks++; if (pe_rx_payload !== m_rxq[0][31:6] || pe_rx_src !== m_rxq[0][5:3]) begin errors++;
                    $display("FAIL rand_rx_head[%0d]: got %h/%0d want %h/%0d", c, pe_rx_payload, pe_rx_src,
                             m_rxq[0][31:6], m_rxq[0][5:3]); end
            end
            checks++; if (tx_cnt !== m_tx_cnt || rx_cnt !== m_rx_cnt || drop_cnt !== m_drop ||
                          rx_overflow !== m_ovf || misroute !== m_mis) begin errors++;
                $display("FAIL rand_stats[%0d]: got %0d/%0d/%0d/%b/%b want %0d/%0d/%0d/%b/%b", c, tx_cnt, rx_cnt,
                         drop_cnt, rx_overflow, misroute, m_tx_cnt, m_rx_cnt, m_drop, m_ovf, m_mis); end
        end
        rst = 0;
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_tx_basic();
        test_tx_backpressure();
        test_rx_overflow();
        test_rx_full_pop();
        test_misroute_clr();
        test_drop_saturate();
        test_reset_midop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
